// File: rtl/icache_stub_pkg.sv
// Shared definitions for the icache response stub.
//   - type_icache_stub_state_e : responder FSM states
//   - DEFAULT_BASE_ADDR        : byte address that maps to RAM word 0
//   - DEFAULT_MEM_WORDS        : default backing RAM depth in words
//   - INDEX_WIDTH              : word-index width for the default depth
//   - addr_in_range/word_index : address decode helpers shared by the
//                                fetch path and the preload path
package icache_stub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } type_icache_stub_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int          DEFAULT_MEM_WORDS = 1024;
  localparam int          INDEX_WIDTH       = $clog2(DEFAULT_MEM_WORDS);

  // The subtraction is unsigned, so addresses below base wrap to a large
  // offset; the explicit addr >= base term keeps that from aliasing.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    return (addr >= base) && (((addr - base) >> 2) < words);
  endfunction

  // Byte offset from base converted to a word index; bits [1:0] drop out.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/icache_stub_ram.sv
// Backing store for the icache stub: one write port, one synchronous read
// port, no reset. On a same-cycle write/read of one word the read returns
// the previous contents.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   re_i    : read enable (rdata_o holds its value when low)
//   raddr_i : read word index
//   rdata_o : registered read data
module icache_stub_ram
  import icache_stub_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Non-blocking write and read in the same block give read-old behaviour.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_resp_stub.sv
// Responder end of the prefetch-to-icache request/ack protocol. Accepts a
// word fetch, waits WAIT_CYCLES, then returns the RAM word with a one-cycle
// ack (or err for addresses outside the RAM window).
//   clk, rst_n           : clock, async active-low reset
//   req_i, addr_i        : fetch request (level, held until ack) and address
//   req_kill_i           : abort the outstanding request
//   r_data_o, ack_o      : response data and one-cycle strobe
//   err_o                : access fault, qualified by ack_o
//   busy_o               : a request is outstanding
//   load_en_i/addr/data  : RAM preload port (same address map as addr_i)
module icache_resp_stub
  import icache_stub_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = DEFAULT_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic                  req_kill_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  input  logic                  load_en_i,
  input  logic [DATA_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [31:0] WORDS     = 32'(MEM_WORDS);

  type_icache_stub_state_e state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic [DATA_WIDTH-1:0]   rd_addr;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_en;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // The RAM is read in the cycle before RESP. With zero wait states that is
  // the acceptance cycle itself, before addr_q has been loaded, so the live
  // address is used while IDLE.
  always_comb begin
    rd_addr = (state_q == IDLE) ? addr_i : addr_q;
    rd_idx  = IDX_W'(word_index(rd_addr, BASE_ADDR));
    rd_en   = (state_d == RESP) && addr_in_range(rd_addr, BASE_ADDR, WORDS);
    wr_idx  = IDX_W'(word_index(load_addr_i, BASE_ADDR));
    wr_en   = load_en_i && addr_in_range(load_addr_i, BASE_ADDR, WORDS);
  end

  icache_stub_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(IDX_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_idx),
    .wdata_i(load_data_i),
    .re_i   (rd_en),
    .raddr_i(rd_idx),
    .rdata_o(ram_rdata)
  );

  // Next-state logic. Response outputs are computed while in RESP and
  // appear on the registered outputs in the following (IDLE) cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_i && !req_kill_i) begin
          addr_d = addr_i;
          if (WAIT_CYCLES == 0) begin
            cnt_d   = 4'd0;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (req_kill_i) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!req_kill_i) begin
          ack_d = 1'b1;
          if (addr_in_range(addr_q, BASE_ADDR, WORDS)) begin
            rdata_d = ram_rdata;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign r_data_o = rdata_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_icache_resp_stub.sv
// Bench for icache_resp_stub. Three instances share all inputs and differ
// only in WAIT_CYCLES (index 0: 2, index 1: 0, index 2: 3); each scenario
// observes one instance. Inputs change and outputs are sampled on negedge.
module tb_icache_resp_stub;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          NI    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic req = 1'b0, kill = 1'b0, load_en = 1'b0;
  logic [31:0] addr = '0, load_addr = '0, load_data = '0;

  logic [NI-1:0]       ack, err, busy;
  logic [NI-1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [WORDS];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    icache_resp_stub #(
      .WAIT_CYCLES((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req),
      .addr_i     (addr),
      .req_kill_i (kill),
      .r_data_o   (rdata[gi]),
      .ack_o      (ack[gi]),
      .err_o      (err[gi]),
      .busy_o     (busy[gi]),
      .load_en_i  (load_en),
      .load_addr_i(load_addr),
      .load_data_i(load_data)
    );
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  // Reference: the RAM window is [BASE, BASE + 4*WORDS).
  function automatic bit model_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    return model_in_range(a) ? model_mem[model_idx(a)] : 32'h0;
  endfunction

  task automatic do_reset();
    req = 1'b0; kill = 1'b0; load_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_addr = a; load_data = d; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    if (model_in_range(a)) model_mem[model_idx(a)] = d;
  endtask

  // Raises req with address a and waits (bounded) for ack on instance k.
  // Returns negedges counted from the request (0 = no ack). req stays high.
  task automatic fetch(input int k, input logic [31:0] a, output int lat,
                       output logic [31:0] d, output logic e);
    req = 1'b1; addr = a; lat = 0; d = '0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[k]) begin
        lat = i; d = rdata[k]; e = err[k];
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({ack[k], err[k], busy[k]} !== 3'b000 || rdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: ack=%b err=%b busy=%b data=%h want all 0",
                 k, ack[k], err[k], busy[k], rdata[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload();
    for (int i = 0; i < WORDS; i++) load_word(BASE + 32'(4 * i), $urandom);
    load_word(BASE + 32'h0, 32'h0000_0013);
    load_word(BASE + 32'h4, 32'h0040_0093);
    load_word(BASE + 32'h14, 32'hAAAA_AAAA);
  endtask

  task automatic test_basic_fetch();
    int lat; logic [31:0] d; logic e;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      fetch(0, BASE + 32'(4 * j), lat, d, e);
      checks++;
      if (lat != 4 || e !== 1'b0 || d !== (j == 0 ? 32'h0000_0013 : 32'h0040_0093)) begin
        errors++;
        $display("FAIL basic_fetch[%0d]: lat=%0d err=%b data=%h want lat=4 err=0 data=%h",
                 j, lat, e, d, (j == 0 ? 32'h0000_0013 : 32'h0040_0093));
      end
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe: ack=%b busy=%b want 0 0", ack[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back_zero_wait();
    int lat; logic [31:0] d; logic e;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      fetch(1, BASE + 32'(4 * j), lat, d, e);
      checks++;
      if (lat != 2 || e !== 1'b0 || d !== model_mem[j]) begin
        errors++;
        $display("FAIL b2b_w0[%0d]: lat=%0d err=%b data=%h want lat=2 err=0 data=%h",
                 j, lat, e, d, model_mem[j]);
      end
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] d; logic e;
    logic [31:0] bad [2];
    bad[0] = 32'h7FFF_FFFC;
    bad[1] = BASE + 32'(4 * WORDS);
    do_reset();
    for (int j = 0; j < 2; j++) begin
      fetch(0, bad[j], lat, d, e);
      checks++;
      if (lat != 4 || e !== 1'b1 || d !== 32'h0) begin
        errors++;
        $display("FAIL oor_fetch[%h]: lat=%0d err=%b data=%h want lat=4 err=1 data=0",
                 bad[j], lat, e, d);
      end
    end
    req = 1'b0;
    @(negedge clk);
    // Out-of-range loads must be dropped, not aliased onto RAM words.
    load_word(bad[1], 32'hDEAD_BEEF);
    load_word(bad[0], 32'hFEED_F00D);
    load_word(BASE + 32'(8 * WORDS), 32'hBAD0_BAD0);
    for (int j = 0; j < 2; j++) begin
      fetch(0, (j == 0) ? BASE : BASE + 32'(4 * (WORDS - 1)), lat, d, e);
      checks++;
      if (lat != 4 || e !== 1'b0 || d !== model_mem[(j == 0) ? 0 : WORDS - 1]) begin
        errors++;
        $display("FAIL oor_load_dropped[%0d]: lat=%0d err=%b data=%h want %h",
                 j, lat, e, d, model_mem[(j == 0) ? 0 : WORDS - 1]);
      end
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_kill();
    int acks; int lat; logic [31:0] d; logic e;
    do_reset();
    // Kill in the second WAIT cycle.
    acks = 0; req = 1'b1; addr = BASE + 32'h8;
    @(negedge clk); acks += int'(ack[2]);
    @(negedge clk); acks += int'(ack[2]);
    checks++;
    if (busy[2] !== 1'b1) begin
      errors++; $display("FAIL kill_wait_busy_before: busy=%b want 1", busy[2]);
    end
    kill = 1'b1;
    @(negedge clk); acks += int'(ack[2]);
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++; $display("FAIL kill_wait_busy_after: busy=%b want 0", busy[2]);
    end
    req = 1'b0; kill = 1'b0;
    repeat (8) begin @(negedge clk); acks += int'(ack[2]); end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL kill_wait_ack: acks=%0d want 0", acks);
    end
    // Kill in the RESP cycle.
    acks = 0; req = 1'b1; addr = BASE + 32'hC;
    repeat (3) begin @(negedge clk); acks += int'(ack[2]); end
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk); acks += int'(ack[2]);
    checks++;
    if (busy[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL kill_resp_outputs: busy=%b err=%b data=%h want 0 0 0",
               busy[2], err[2], rdata[2]);
    end
    req = 1'b0; kill = 1'b0;
    repeat (8) begin @(negedge clk); acks += int'(ack[2]); end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL kill_resp_ack: acks=%0d want 0", acks);
    end
    // Kill together with req in IDLE.
    acks = 0; req = 1'b1; kill = 1'b1; addr = BASE + 32'h10;
    @(negedge clk); acks += int'(ack[2]);
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++; $display("FAIL kill_idle_busy: busy=%b want 0", busy[2]);
    end
    repeat (6) begin @(negedge clk); acks += int'(ack[2]); end
    req = 1'b0; kill = 1'b0;
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL kill_idle_ack: acks=%0d want 0", acks);
    end
    // A plain fetch still works afterwards.
    repeat (6) @(negedge clk);
    fetch(2, BASE + 32'h10, lat, d, e);
    req = 1'b0;
    checks++;
    if (lat != 5 || e !== 1'b0 || d !== model_mem[4]) begin
      errors++;
      $display("FAIL kill_recover: lat=%0d err=%b data=%h want lat=5 err=0 data=%h",
               lat, e, d, model_mem[4]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_collision();
    int lat; logic [31:0] d; logic e; logic [31:0] old_val;
    do_reset();
    load_word(BASE + 32'h14, 32'hAAAA_AAAA);
    old_val = model_mem[5];
    req = 1'b1; addr = BASE + 32'h14;
    @(negedge clk);
    @(negedge clk);
    // This is the RAM read cycle for a 2-wait-state fetch.
    load_addr = BASE + 32'h14; load_data = 32'h5555_5555; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    model_mem[5] = 32'h5555_5555;
    @(negedge clk);
    checks++;
    if (ack[0] !== 1'b1 || rdata[0] !== old_val) begin
      errors++;
      $display("FAIL collision_old: ack=%b data=%h want ack=1 data=%h", ack[0], rdata[0], old_val);
    end
    fetch(0, BASE + 32'h14, lat, d, e);
    req = 1'b0;
    checks++;
    if (lat != 4 || d !== 32'h5555_5555) begin
      errors++;
      $display("FAIL collision_new: lat=%0d data=%h want lat=4 data=55555555", lat, d);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int acks; int lat; logic [31:0] d; logic e;
    do_reset();
    acks = 0; req = 1'b1; addr = BASE + 32'hC;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack[0], err[0], busy[0]} !== 3'b000 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: ack=%b err=%b busy=%b data=%h want all 0",
               ack[0], err[0], busy[0], rdata[0]);
    end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); acks += int'(ack[0]); end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_mid_noack: acks=%0d want 0", acks);
    end
    fetch(0, BASE + 32'hC, lat, d, e);
    req = 1'b0;
    checks++;
    if (lat != 4 || e !== 1'b0 || d !== model_mem[3]) begin
      errors++;
      $display("FAIL reset_mid_recover: lat=%0d err=%b data=%h want lat=4 err=0 data=%h",
               lat, e, d, model_mem[3]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] d; logic e; logic [31:0] a; int k;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 99) < 85)
        a = BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0)
        a = $urandom & 32'h7FFF_FFFF;
      else
        a = BASE + 32'(4 * WORDS) + ($urandom & 32'h0FFF_FFFF);
      if ($urandom_range(0, 3) == 0) begin
        load_word(a, $urandom);
      end else begin
        k = $urandom_range(0, NI - 1);
        fetch(k, a, lat, d, e);
        req = 1'b0;
        checks++;
        if (lat != wait_of(k) + 2 || e !== !model_in_range(a) || d !== model_data(a)) begin
          errors++;
          $display("FAIL random[%0d] inst%0d addr=%h: lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                   n, k, a, lat, e, d, wait_of(k) + 2, !model_in_range(a), model_data(a));
        end
        repeat (6) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic_fetch();
    test_back_to_back_zero_wait();
    test_out_of_range();
    test_kill();
    test_collision();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_resp_stub.md
Name: icache_resp_stub

Overview:
- Instruction-side memory responder: the responder end of the prefetch-to-icache request/ack protocol.
- Accepts word fetch requests from the prefetch unit and returns r_data with a one-cycle ack after a programmable number of wait states.
- Backed by a word-addressed on-chip RAM, preloaded through a load port.
- Used as the icache stand-in for prefetch/fetch bring-up and as a boot ROM model in small configurations.

Parameters:
- DATA_WIDTH, 32, width of the fetch word and the address.
- MEM_WORDS, 1024, depth of the backing RAM in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000, physical byte address of word 0.
- WAIT_CYCLES, 2, wait states between acceptance and ack; legal range 0..15.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- req_i  in  1  fetch request. Level signal; the requester holds it with a stable addr_i until ack_o.
- addr_i  in  32  physical byte address of the fetch.
- req_kill_i  in  1  abort of the outstanding request (pipeline flush).
- r_data_o  out  32  fetched instruction word. Valid only while ack_o=1.
- ack_o  out  1  one-cycle response strobe.
- err_o  out  1  access fault. Qualified by ack_o.
- busy_o  out  1  a request is outstanding (state != IDLE).
- load_en_i  in  1  RAM preload write enable.
- load_addr_i  in  32  preload byte address (absolute, same map as addr_i).
- load_data_i  in  32  preload word.

Behaviour:
- Reset values:
  - state=IDLE, wait counter=0.
  - ack_o=0, err_o=0, r_data_o=0, busy_o=0.
  - RAM contents are not reset.
- All outputs are registered.
- FSM states:
  - IDLE: req_i=1 and req_kill_i=0 → latch addr_i, load counter with WAIT_CYCLES, go to WAIT. If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: counter decrements each cycle; go to RESP when it reaches 0. req_kill_i=1 → IDLE, no ack.
  - RESP: ack_o=1 for exactly this cycle, with r_data_o/err_o; next state IDLE unconditionally. req_kill_i=1 in RESP suppresses ack_o and err_o, and r_data_o is forced to 0.
- Latency: with acceptance at clock edge N, ack_o is high in the cycle following edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: ack one cycle after acceptance.
- No request is accepted in RESP. req_i still high in RESP is the request being acked. req_i high in the following IDLE cycle is a new request, so the minimum request period is WAIT_CYCLES+2 cycles.
- Addressing:
  - addr_i[1:0] is ignored (word fetch); halfword selection belongs to the prefetch unit.
  - Word index = (addr - BASE_ADDR) >> 2, unsigned 32-bit subtraction.
  - In range iff addr ≥ BASE_ADDR and index < MEM_WORDS.
  - Out of range → ack_o=1, err_o=1, r_data_o=0.
- Read timing: the RAM is read with the latched address in the last cycle before RESP; data is registered into r_data_o.
- Load port:
  - Writes on any cycle when load_en_i=1 and the load address is in range.
  - Out-of-range loads are silently dropped.
  - A load to the word being read in the same cycle: the read returns the old data; the new data is visible to later fetches.
- Simultaneous req_i and req_kill_i in IDLE: the request is ignored and remains IDLE.
- Reset asserted mid-WAIT or mid-RESP: the request is dropped, and no ack follows reset release.
- busy_o=1 in WAIT and RESP.

Decomposition:
- Shared package icache_stub_pkg holds:
  - the state enum type_icache_stub_state_e {IDLE, WAIT, RESP};
  - a constant for the default BASE_ADDR;
  - localparam-derived INDEX_WIDTH = $clog2(MEM_WORDS).
- Sub-module icache_stub_ram: one write port plus one synchronous read port, no reset, read-old-on-collision. Holds the storage array only.
- FSM, counter, range check and output registers live in icache_resp_stub.

Test Plan:
- Basic fetch:
  - Stimulus: WAIT_CYCLES=2, preload word 0 = 32'h0000_0013, word 1 = 32'h0040_0093. req_i=1, addr_i=32'h8000_0000, held until ack.
  - Response: ack_o high exactly 3 cycles after acceptance, r_data_o=32'h0000_0013, err_o=0. A following request to 32'h8000_0004 returns 32'h0040_0093.
- Zero-wait back-to-back:
  - Stimulus: WAIT_CYCLES=0, six consecutive fetches at 0x8000_0000 + 4k.
  - Response: each ack arrives one cycle after acceptance, 2-cycle request period, data in order.
- Out-of-range access:
  - Stimulus: addr_i=32'h7FFF_FFFC; then addr_i=BASE_ADDR + 4*MEM_WORDS.
  - Response: each gives ack_o=1, err_o=1, r_data_o=0; the RAM is not touched.
- Kill:
  - Stimulus: WAIT_CYCLES=3, kill in the second WAIT cycle; separately, kill in the RESP cycle; separately, kill together with req in IDLE.
  - Response: ack_o never rises in any case; busy_o returns to 0 the next cycle.
- Load/read collision:
  - Stimulus: fetch word 5 (old value 32'hAAAA_AAAA) while load_en_i writes 32'h5555_5555 to word 5 in the read cycle.
  - Response: the ack returns 32'hAAAA_AAAA; a second fetch returns 32'h5555_5555.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT (between clock edges).
  - Response: outputs go to 0 immediately, no ack after release, and the next request completes normally.
